// File: rtl/aud_recorder_if.sv
// SRAM write port driven by the audio recorder.
interface aud_recorder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20
);
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data;
  logic              sram_we;

  modport master (output sram_addr, output sram_data, output sram_we);
  modport slave  (input  sram_addr, input  sram_data, input  sram_we);
endinterface

// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures one DATA_W-bit left sample per LRC
// period and writes it to consecutive SRAM words, with pause/resume/stop.
module aud_recorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_data,
  aud_recorder_if.master    sram,
  output logic [ADDR_W-1:0] o_stop_addr,
  output logic              o_fin,
  output logic [2:0]        o_state
);
  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              lrc_prev;
  logic              frame_start;
  logic              addr_clr, addr_inc, cnt_clr, shift_en, load_data, end_rec, we;

  assign frame_start = lrc_prev & ~i_lrc;

  // Delayed LRC for detecting the start of a left-channel frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lrc_prev <= 1'b0;
    else       lrc_prev <= i_lrc;
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control; stop outranks pause outranks start.
  always_comb begin
    state_d   = state_q;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    end_rec   = 1'b0;
    we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          addr_clr = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_stop) begin
          end_rec = 1'b1;
          state_d = ST_IDLE;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else if (frame_start) begin
          // This cycle is the I2S one-bit delay; sampling begins next cycle.
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_stop) begin
          end_rec = 1'b1;
          state_d = ST_IDLE;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else begin
          shift_en = 1'b1;
          if (cnt_q == LAST_BIT) begin
            load_data = 1'b1;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // Strobe is gated by i_stop in the same cycle so a stop cancels the write.
        if (i_stop) begin
          end_rec = 1'b1;
          state_d = ST_IDLE;
        end else begin
          we = 1'b1;
          if (addr_q == '1) begin
            end_rec = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_inc = 1'b1;
            state_d  = i_pause ? ST_PAUSE : ST_WAIT;
          end
        end
      end
      ST_PAUSE: begin
        if (i_stop) begin
          end_rec = 1'b1;
          state_d = ST_IDLE;
        end else if (!i_pause && i_start) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, shift register, bit counter, sample and end-of-recording registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      o_stop_addr <= '0;
      o_fin       <= 1'b0;
    end else begin
      o_fin <= end_rec;
      if (end_rec)       o_stop_addr <= addr_q;
      if (addr_clr)      addr_q      <= '0;
      else if (addr_inc) addr_q      <= addr_q + ADDR_W'(1);
      if (cnt_clr)       cnt_q       <= '0;
      else if (shift_en) cnt_q       <= cnt_q + CNT_W'(1);
      if (shift_en)      shift_q     <= {shift_q[DATA_W-2:0], i_data};
      if (load_data)     data_q      <= {shift_q[DATA_W-2:0], i_data};
    end
  end

  assign sram.sram_we   = we;
  assign sram.sram_addr = addr_q;
  assign sram.sram_data = data_q;
  assign o_state        = state_q;
endmodule
